// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS       = 8;
    localparam int DEFAULT_DIVISOR = 868;
    localparam int DEFAULT_CNT_W   = 16;

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts clk cycles and flags the last cycle of each bit period.
module baud_counter #(
    parameter int DIVISOR = 868,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == TERMINAL);

    // Terminal count wraps to zero so each bit period is exactly DIVISOR cycles.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream FIFO and shifts them out as 8N1 UART frames, LSB first.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DIVISOR = DEFAULT_DIVISOR,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 empty,
    input  logic [DATA_BITS-1:0] r_data,
    output logic                 rd,
    output logic                 tx,
    output logic                 busy,
    output logic                 done_tick,
    output uart_state_e          state_dbg
);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_q, bit_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;

    // Holding the counter clear through IDLE makes START begin at count zero.
    baud_counter #(
        .DIVISOR (DIVISOR),
        .CNT_W   (CNT_W)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    // Pop strobe is combinational so r_data is captured on the same edge it is popped.
    assign rd        = reset && (state_q == IDLE) && en && !empty;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done_tick = done_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd) begin
                    shift_d = r_data;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is derived from the next state so it is registered with no extra lag.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a FIFO model and a frame-level scoreboard.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int DIV   = 4;
    localparam int FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        rd;
    logic        tx;
    logic        busy;
    logic        done_tick;
    uart_state_e state_dbg;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DIVISOR (DIV),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .empty     (empty),
        .r_data    (r_data),
        .rd        (rd),
        .tx        (tx),
        .busy      (busy),
        .done_tick (done_tick),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] push_req[$];
    logic [9:0] exp_q[$];
    int         rd_times[$];
    int         rd_cnt = 0;
    int         done_cnt = 0;
    logic       rd_pend = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // FIFO model: pops after the edge that consumed the head, absorbs queued writes.
    always @(posedge clk) begin
        logic [7:0] junk;
        cyc++;
        #1;
        if (rd_pend && reset && fifo_q.size() > 0) junk = fifo_q.pop_front();
        while (push_req.size() > 0) begin
            junk = push_req.pop_front();
            fifo_q.push_back(junk);
        end
        empty  = (fifo_q.size() == 0);
        r_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    end

    // Monitor: captures each frame sample-by-sample and scores it against exp_q.
    logic        mon_active = 1'b0;
    int          idx = 0;
    logic [39:0] frame_s;
    logic [39:0] exp40;
    logic        busy_bad;
    logic        done_bad;

    always @(negedge clk) begin
        logic [9:0] pat;
        if (!reset) begin
            mon_active = 1'b0;
            rd_pend    = 1'b0;
        end else begin
            if (rd) begin
                rd_cnt++;
                rd_times.push_back(cyc);
            end
            if (done_tick) done_cnt++;
            if (mon_active) begin
                if (idx < FRAME) begin
                    frame_s[idx] = tx;
                    if (!busy) busy_bad = 1'b1;
                    if (done_tick) done_bad = 1'b1;
                    idx++;
                end else begin
                    check("frame_bits", frame_s, exp40);
                    check("frame_busy_drop", busy_bad, 1'b0);
                    check("frame_done_early", done_bad, 1'b0);
                    check("gap_tx_busy_done", {tx, busy, done_tick}, 3'b101);
                    mon_active = 1'b0;
                end
            end else if (tx == 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit with empty scoreboard (cycle %0d)", cyc);
                    pat = 10'h000;
                end else begin
                    pat = exp_q.pop_front();
                end
                for (int i = 0; i < FRAME; i++) exp40[i] = pat[i / DIV];
                frame_s    = '0;
                frame_s[0] = tx;
                busy_bad   = !busy;
                done_bad   = done_tick;
                idx        = 1;
                mon_active = 1'b1;
            end
            rd_pend = rd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_req.push_back(b);
        exp_q.push_back({1'b1, b, 1'b0});
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2000; i++) begin
            if (!busy && fifo_q.size() == 0 && push_req.size() == 0 && !mon_active) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("idle_reached", ok, 1'b1);
    endtask

    task automatic wait_rd();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rd) begin
                ok = 1'b1;
                break;
            end
        end
        check("rd_seen", ok, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rd0;
        int   d0;
        int   base;
        logic bad;
        logic ok;

        // 1. reset and idle
        en = 1'b1;
        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_rd", rd, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done_tick, 1'b0);
        check("rst_state", state_dbg, IDLE);
        reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("idle_50", bad, 1'b0);

        // 2. single byte 8'hA5
        rd0 = rd_cnt;
        d0  = done_cnt;
        push_byte(8'hA5);
        wait_idle();
        check("a5_rd_pulses", rd_cnt - rd0, 1);
        check("a5_done_pulses", done_cnt - d0, 1);
        check("a5_busy_after", busy, 1'b0);

        // 3. back-to-back 8'h00 then 8'hFF
        base = rd_times.size();
        d0   = done_cnt;
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_idle();
        check("b2b_rd_count", rd_times.size() - base, 2);
        if (rd_times.size() - base == 2) check("b2b_pitch", rd_times[base + 1] - rd_times[base], 41);
        check("b2b_done_pulses", done_cnt - d0, 2);
        check("b2b_empty", empty, 1'b1);

        // 4. enable gating with 8'h3C
        en  = 1'b0;
        rd0 = rd_cnt;
        push_byte(8'h3C);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1 || rd !== 1'b0) bad = 1'b1;
        end
        check("gated_quiet", bad, 1'b0);
        check("gated_no_pop", rd_cnt - rd0, 0);
        en = 1'b1;
        #1;
        check("pop_on_enable", rd, 1'b1);
        repeat (8) tick();
        check("en_drop_in_data", state_dbg, DATA);
        en = 1'b0;
        push_byte(8'h99);
        repeat (50) tick();
        check("en_drop_one_pop", rd_cnt - rd0, 1);
        check("en_drop_held", {state_dbg, empty}, {IDLE, 1'b0});

        // 5. reset mid-frame: 8'h99 drains first, then 8'h55 is aborted in DATA bit 3
        en = 1'b1;
        wait_idle();
        push_byte(8'h55);
        wait_rd();
        repeat (18) tick();
        check("pre_reset_data", state_dbg, DATA);
        reset = 1'b0;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_state", state_dbg, IDLE);
        exp_q.delete();
        repeat (3) tick();
        reset = 1'b1;
        push_byte(8'h81);
        wait_idle();

        // 6. late arrival during STOP
        base = rd_times.size();
        push_byte(8'h11);
        wait_rd();
        tick();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (state_dbg == STOP) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("reached_stop", ok, 1'b1);
        push_byte(8'h7E);
        wait_idle();
        check("late_rd_count", rd_times.size() - base, 2);
        if (rd_times.size() - base == 2) check("late_pitch", rd_times[base + 1] - rd_times[base], 41);

        repeat (5) tick();
        check("exp_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
